serial_route_ctrl: RTL and testbench

SERIAL_ROUTE_CTRL -- requirements
Module: serial_route_ctrl

---
 rtl/serial_route_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_route_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_route_ctrl.sv
// Serial frame decoder that routes a frame's data bits to one of four ports.
// Optional even-parity check is compiled in with SERIAL_ROUTE_PARITY_EN.
module serial_route_ctrl #(
    parameter int LEN_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serIn,
    output logic       serOut,
    output logic [0:3] PB,
    output logic [1:0] LB,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PORT = 3'd1,
        LINE = 3'd2,
        LEN  = 3'd3,
        DATA = 3'd4
`ifdef SERIAL_ROUTE_PARITY_EN
        , PAR = 3'd5
`endif
    } state_t;

    state_t             state_r, state_s;
    logic               run_r;
    logic               srst_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [1:0]         port_r, port_s;
    logic               line_hi_r, line_hi_s;
    logic [1:0]         lb_r, lb_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic               ser_out_r, ser_out_s;
    logic [0:3]         pb_r, pb_s;
    logic               busy_r;
    logic               done_r, done_s;

    function automatic logic [0:3] port_onehot(input logic [1:0] sel);
        logic [0:3] oh;
        oh      = 4'b0000;
        oh[sel] = 1'b1;
        return oh;
    endfunction

`ifdef SERIAL_ROUTE_PARITY_EN
    logic par_r, par_s;
    logic err_r, err_s;

    function automatic logic parity_acc(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction
`endif

    // Release synchroniser: the FSM is held in its reset state until one edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    assign srst_s = ~run_r;

    // Next-state and next-output decode; IDLE also samples a start bit on the cycle after a frame.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r + CNT_W'(1);
        port_s    = port_r;
        line_hi_s = line_hi_r;
        lb_s      = lb_r;
        len_s     = len_r;
        ser_out_s = 1'b0;
        pb_s      = 4'b0000;
        done_s    = 1'b0;
`ifdef SERIAL_ROUTE_PARITY_EN
        err_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (!serIn) begin
                    state_s = PORT;
                end else begin
                    state_s = IDLE;
                end
            end
            PORT: begin
                port_s = {port_r[0], serIn};
                if (cnt_r == CNT_W'(1)) begin
                    state_s = LINE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = PORT;
                end
            end
            LINE: begin
                // LB only updates once both bits are in, so it never shows a half code.
                if (cnt_r == CNT_W'(0)) begin
                    line_hi_s = serIn;
                end else begin
                    lb_s    = {line_hi_r, serIn};
                    state_s = LEN;
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            LEN: begin
                len_s = {len_r[LEN_W-2:0], serIn};
                if (cnt_r == CNT_W'(LEN_W - 1)) begin
                    state_s = DATA;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = LEN;
                end
            end
            DATA: begin
                ser_out_s = serIn;
                pb_s      = port_onehot(port_r);
                if (cnt_r == {1'b0, len_r}) begin
                    cnt_s = {CNT_W{1'b0}};
`ifdef SERIAL_ROUTE_PARITY_EN
                    state_s = PAR;
`else
                    state_s = IDLE;
                    done_s  = 1'b1;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef SERIAL_ROUTE_PARITY_EN
            PAR: begin
                cnt_s   = {CNT_W{1'b0}};
                done_s  = 1'b1;
                err_s   = parity_acc(par_r, serIn);
                state_s = IDLE;
            end
`endif
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
`ifdef SERIAL_ROUTE_PARITY_EN
        if (state_r == IDLE) begin
            par_s = 1'b0;
        end else if ((state_r == PORT) || (state_r == LINE) || (state_r == LEN) || (state_r == DATA)) begin
            par_s = parity_acc(par_r, serIn);
        end else begin
            par_s = par_r;
        end
`endif
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            port_r    <= 2'b00;
            line_hi_r <= 1'b0;
            lb_r      <= 2'b00;
            len_r     <= {LEN_W{1'b0}};
            ser_out_r <= 1'b0;
            pb_r      <= 4'b0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (srst_s) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            port_r    <= 2'b00;
            line_hi_r <= 1'b0;
            lb_r      <= 2'b00;
            len_r     <= {LEN_W{1'b0}};
            ser_out_r <= 1'b0;
            pb_r      <= 4'b0000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            port_r    <= port_s;
            line_hi_r <= line_hi_s;
            lb_r      <= lb_s;
            len_r     <= len_s;
            ser_out_r <= ser_out_s;
            pb_r      <= pb_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= done_s;
        end
    end

`ifdef SERIAL_ROUTE_PARITY_EN
    // Parity accumulator and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= 1'b0;
            err_r <= 1'b0;
        end else if (srst_s) begin
            par_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            par_r <= par_s;
            err_r <= err_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign serOut = ser_out_r;
    assign PB     = pb_r;
    assign LB     = lb_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_serial_route_ctrl.sv
// Directed self-checking bench for serial_route_ctrl; covers both builds of SERIAL_ROUTE_PARITY_EN.
module tb_serial_route_ctrl;

    logic       clk;
    logic       rst_n;
    logic       serIn;
    logic       serOut;
    logic [0:3] PB;
    logic [1:0] LB;
    logic       busy;
    logic       done;
    logic       err;

    int checks;
    int errors;

    serial_route_ctrl #(.LEN_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .serIn  (serIn),
        .serOut (serOut),
        .PB     (PB),
        .LB     (LB),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one serial bit, let the DUT sample it, then settle just after the edge.
    task automatic step(input logic b);
        serIn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] p, input logic [1:0] l, input logic [3:0] n,
                              input logic [15:0] d, input logic bad_par, input logic with_start);
        logic [0:3] pb_exp;
        logic       par;
        pb_exp    = 4'b0000;
        pb_exp[p] = 1'b1;
        par       = (^p) ^ (^l) ^ (^n);
        if (with_start) begin
            step(1'b0);
            chk("busy_after_start", {15'd0, busy}, 16'd1);
        end
        for (int i = 1; i >= 0; i--) step(p[i]);
        for (int i = 1; i >= 0; i--) step(l[i]);
        chk("lb_after_line", {14'd0, LB}, {14'd0, l});
        for (int i = 3; i >= 0; i--) step(n[i]);
        chk("pb_idle_before_data", {12'd0, PB}, 16'd0);
        for (int i = int'(n); i >= 0; i--) begin
            step(d[i]);
            par = par ^ d[i];
            chk("data_serout", {15'd0, serOut}, {15'd0, d[i]});
            chk("data_pb", {12'd0, PB}, {12'd0, pb_exp});
`ifdef SERIAL_ROUTE_PARITY_EN
            chk("data_done", {15'd0, done}, 16'd0);
`else
            chk("data_done", {15'd0, done}, (i == 0) ? 16'd1 : 16'd0);
            if (i == 0) begin
                chk("done_err", {15'd0, err}, 16'd0);
                chk("done_busy", {15'd0, busy}, 16'd0);
            end
`endif
        end
`ifdef SERIAL_ROUTE_PARITY_EN
        step(par ^ bad_par);
        chk("par_done", {15'd0, done}, 16'd1);
        chk("par_err", {15'd0, err}, {15'd0, bad_par});
        chk("par_pb", {12'd0, PB}, 16'd0);
        chk("par_busy", {15'd0, busy}, 16'd0);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        serIn  = 1'b1;
        #12;
        chk("rst_pb", {12'd0, PB}, 16'd0);
        chk("rst_lb", {14'd0, LB}, 16'd0);
        chk("rst_flags", {12'd0, serOut, busy, done, err}, 16'd0);

        // Release with a start level already present: first state change on the second edge.
        serIn = 1'b0;
        rst_n = 1'b1;
        step(1'b0);
        chk("sync_edge1_busy", {15'd0, busy}, 16'd0);
        step(1'b0);
        chk("sync_edge2_busy", {15'd0, busy}, 16'd1);
        // Finish that frame: p=00, l=11, n=0000, data 1.
        send_frame(2'b00, 2'b11, 4'b0000, 16'h0001, 1'b0, 1'b0);
        step(1'b1);
        chk("post_frame_done", {15'd0, done}, 16'd0);
        chk("post_frame_pb", {12'd0, PB}, 16'd0);
        chk("lb_held_idle", {14'd0, LB}, 16'd3);

        // Basic frame: p=10, l=01, n=0011, data 1011.
        send_frame(2'b10, 2'b01, 4'b0011, 16'h000B, 1'b0, 1'b1);
        step(1'b1);
        chk("basic_done_fall", {15'd0, done}, 16'd0);
        chk("basic_pb_fall", {12'd0, PB}, 16'd0);

        // Maximum length: 16 data bits, no counter wrap.
        send_frame(2'b01, 2'b10, 4'b1111, 16'hA5C3, 1'b0, 1'b1);
        step(1'b1);
        chk("max_pb_fall", {12'd0, PB}, 16'd0);
        chk("max_done_single", {15'd0, done}, 16'd0);
        chk("max_busy", {15'd0, busy}, 16'd0);

        // Back-to-back: second start bit sampled in the done cycle.
        send_frame(2'b11, 2'b00, 4'b0010, 16'h0005, 1'b0, 1'b1);
        send_frame(2'b00, 2'b11, 4'b0001, 16'h0002, 1'b1, 1'b1);
        step(1'b1);
        chk("b2b_done_fall", {15'd0, done}, 16'd0);

        // Reset during DATA of a p=11 frame.
        step(1'b0);
        step(1'b1); step(1'b1);
        step(1'b1); step(1'b0);
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        step(1'b1); step(1'b0);
        chk("pre_abort_pb", {12'd0, PB}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_pb", {12'd0, PB}, 16'd0);
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_serout", {15'd0, serOut}, 16'd0);
        chk("abort_lb", {14'd0, LB}, 16'd0);
        step(1'b0);
        chk("abort_no_done", {15'd0, done}, 16'd0);
        #3;
        rst_n = 1'b1;
        step(1'b0);
        chk("rel_edge1_busy", {15'd0, busy}, 16'd0);
        step(1'b0);
        chk("rel_edge2_busy", {15'd0, busy}, 16'd1);
        send_frame(2'b01, 2'b01, 4'b0100, 16'h0016, 1'b0, 1'b0);

        // Idle line held high for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            step(1'b1);
            chk("idle_busy_pb", {11'd0, busy, PB}, 16'd0);
        end
        chk("idle_done", {15'd0, done}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
